// File: rtl/branch_predictor.sv
// Direct-mapped BTB with a 2-bit saturating counter per entry; lookup is combinational, update at posedge.
// PC width comes from `WORD_SIZE (16 if not defined); `BP_STATS_EN builds the branch/mispredict counters.
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

module branch_predictor #(
   parameter int IDX_BITS = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [`WORD_SIZE-1:0] if_pc,
   output logic                  pred_taken,
   output logic [`WORD_SIZE-1:0] pred_target,
   output logic [`WORD_SIZE-1:0] pred_pc_next,
   input  logic                  upd_valid,
   input  logic [`WORD_SIZE-1:0] upd_pc,
   input  logic                  upd_taken,
   input  logic [`WORD_SIZE-1:0] upd_target,
   input  logic                  upd_pred_taken,
   input  logic [`WORD_SIZE-1:0] upd_pred_target,
   output logic                  mispredict,
   output logic [`WORD_SIZE-1:0] redirect_pc,
   output logic [15:0]           stat_branches,
   output logic [15:0]           stat_mispredicts
);
   localparam int W       = `WORD_SIZE;
   localparam int TAG_W   = W - IDX_BITS;
   localparam int ENTRIES = 2 ** IDX_BITS;
   localparam logic [W-1:0] PC_ONE = W'(1);

   logic             valid_q  [ENTRIES];
   logic [TAG_W-1:0] tag_q    [ENTRIES];
   logic [W-1:0]     target_q [ENTRIES];
   logic [1:0]       ctr_q    [ENTRIES];

   logic [IDX_BITS-1:0] lk_idx, up_idx;
   logic [TAG_W-1:0]    lk_tag, up_tag;
   logic                lk_hit, up_hit;
   logic                wr_en;
   logic [1:0]          ctr_d;
   logic [W-1:0]        target_d;

   assign lk_idx = if_pc[IDX_BITS-1:0];
   assign lk_tag = if_pc[W-1:IDX_BITS];
   assign up_idx = upd_pc[IDX_BITS-1:0];
   assign up_tag = upd_pc[W-1:IDX_BITS];
   assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
   assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

   // Lookup sees the registered table only, so a same-cycle update is visible next cycle.
   assign pred_taken   = lk_hit && ctr_q[lk_idx][1];
   assign pred_target  = lk_hit ? target_q[lk_idx] : '0;
   assign pred_pc_next = pred_taken ? target_q[lk_idx] : if_pc + PC_ONE;

   assign mispredict  = upd_valid && ((upd_taken != upd_pred_taken) ||
                                      (upd_taken && (upd_target != upd_pred_target)));
   assign redirect_pc = upd_taken ? upd_target : upd_pc + PC_ONE;

   always_comb begin
      wr_en    = 1'b0;
      ctr_d    = ctr_q[up_idx];
      target_d = target_q[up_idx];
      if (upd_valid) begin
         if (up_hit) begin
            wr_en = 1'b1;
            if (upd_taken) begin
               ctr_d    = (ctr_q[up_idx] == 2'b11) ? 2'b11 : ctr_q[up_idx] + 2'd1;
               target_d = upd_target;
            end else begin
               ctr_d = (ctr_q[up_idx] == 2'b00) ? 2'b00 : ctr_q[up_idx] - 2'd1;
            end
         end else if (upd_taken) begin
            // A taken miss replaces whatever aliases on this index, starting weakly taken.
            wr_en    = 1'b1;
            ctr_d    = 2'b10;
            target_d = upd_target;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i]  <= 1'b0;
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            ctr_q[i]    <= 2'b01;
         end
      end else if (wr_en) begin
         valid_q[up_idx]  <= 1'b1;
         tag_q[up_idx]    <= up_tag;
         target_q[up_idx] <= target_d;
         ctr_q[up_idx]    <= ctr_d;
      end
   end

`ifdef BP_STATS_EN
   logic [15:0] branches_q, branches_d;
   logic [15:0] mispredicts_q, mispredicts_d;

   always_comb begin
      branches_d    = branches_q;
      mispredicts_d = mispredicts_q;
      if (upd_valid && (branches_q != 16'hFFFF))
         branches_d = branches_q + 16'd1;
      if (mispredict && (mispredicts_q != 16'hFFFF))
         mispredicts_d = mispredicts_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         branches_q    <= 16'h0000;
         mispredicts_q <= 16'h0000;
      end else begin
         branches_q    <= branches_d;
         mispredicts_q <= mispredicts_d;
      end
   end

   assign stat_branches    = branches_q;
   assign stat_mispredicts = mispredicts_q;
`else
   assign stat_branches    = 16'h0000;
   assign stat_mispredicts = 16'h0000;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed vector table, hand sequences for stats/reset, and
// randomized traffic against a table-of-records reference model.
module tb_branch_predictor;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] if_pc;
   logic        pred_taken;
   logic [15:0] pred_target;
   logic [15:0] pred_pc_next;
   logic        upd_valid;
   logic [15:0] upd_pc;
   logic        upd_taken;
   logic [15:0] upd_target;
   logic        upd_pred_taken;
   logic [15:0] upd_pred_target;
   logic        mispredict;
   logic [15:0] redirect_pc;
   logic [15:0] stat_branches;
   logic [15:0] stat_mispredicts;

   int total = 0;
   int bad   = 0;
   logic [15:0] exp_q[$];

   always #5 clk = ~clk;

   branch_predictor dut (
      .clk(clk), .reset(reset), .if_pc(if_pc),
      .pred_taken(pred_taken), .pred_target(pred_target), .pred_pc_next(pred_pc_next),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
      .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
      .mispredict(mispredict), .redirect_pc(redirect_pc),
      .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
   );

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [15:0] pc, input logic uv, input logic [15:0] upc,
                        input logic ut, input logic [15:0] utg, input logic upt,
                        input logic [15:0] uptg);
      if_pc           = pc;
      upd_valid       = uv;
      upd_pc          = upc;
      upd_taken       = ut;
      upd_target      = utg;
      upd_pred_taken  = upt;
      upd_pred_target = uptg;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] exp_stat(input int n);
`ifdef BP_STATS_EN
      return (n > 65535) ? 16'hFFFF : 16'(n);
`else
      return 16'h0000 + 16'(n * 0);
`endif
   endfunction

   // ---------------- reference model ----------------
   typedef struct {
      bit          valid;
      logic [15:0] pc;
      logic [15:0] target;
      int          strength;
   } ent_t;
   ent_t m_tbl[16];
   int   m_br, m_mp;

   function automatic int slot(input logic [15:0] pc);
      return int'(pc[3:0]);
   endfunction

   function automatic bit m_hit(input logic [15:0] pc);
      return m_tbl[slot(pc)].valid && ((m_tbl[slot(pc)].pc >> 4) == (pc >> 4));
   endfunction

   function automatic bit m_taken(input logic [15:0] pc);
      return m_hit(pc) && (m_tbl[slot(pc)].strength >= 2);
   endfunction

   function automatic logic [15:0] m_target(input logic [15:0] pc);
      return m_hit(pc) ? m_tbl[slot(pc)].target : 16'h0000;
   endfunction

   function automatic logic [15:0] m_next(input logic [15:0] pc);
      return m_taken(pc) ? m_tbl[slot(pc)].target : 16'(pc + 16'd1);
   endfunction

   task automatic m_clear();
      for (int i = 0; i < 16; i++) begin
         m_tbl[i].valid = 0; m_tbl[i].pc = 0; m_tbl[i].target = 0; m_tbl[i].strength = 1;
      end
      m_br = 0;
      m_mp = 0;
   endtask

   task automatic m_update(input logic [15:0] pc, input bit taken, input logic [15:0] tgt, input bit mp);
      int s;
      s = slot(pc);
      m_br++;
      if (mp) m_mp++;
      if (m_hit(pc)) begin
         if (taken) begin
            m_tbl[s].strength = (m_tbl[s].strength < 3) ? m_tbl[s].strength + 1 : 3;
            m_tbl[s].target   = tgt;
         end else begin
            m_tbl[s].strength = (m_tbl[s].strength > 0) ? m_tbl[s].strength - 1 : 0;
         end
      end else if (taken) begin
         m_tbl[s].valid = 1; m_tbl[s].pc = pc; m_tbl[s].target = tgt; m_tbl[s].strength = 2;
      end
   endtask

   function automatic logic [15:0] rand_pc();
      if ($urandom_range(0, 15) == 0) return 16'hFFFF;
      return 16'(($urandom_range(0, 2) * 256) + $urandom_range(0, 3));
   endfunction

   // ---------------- directed vectors ----------------
   typedef struct {
      logic [15:0] if_pc;
      logic        uv;
      logic [15:0] upc;
      logic        ut;
      logic [15:0] utg;
      logic        upt;
      logic [15:0] uptg;
      logic        e_pt;
      logic [15:0] e_next;
      logic        e_mp;
      logic [15:0] e_red;
   } vec_t;
   vec_t vecs[22];

   function automatic vec_t mk(input logic [15:0] pc, input logic uv, input logic [15:0] upc,
                               input logic ut, input logic [15:0] utg, input logic upt,
                               input logic [15:0] uptg, input logic e_pt, input logic [15:0] e_next,
                               input logic e_mp, input logic [15:0] e_red);
      vec_t v;
      v.if_pc = pc; v.uv = uv; v.upc = upc; v.ut = ut; v.utg = utg; v.upt = upt; v.uptg = uptg;
      v.e_pt = e_pt; v.e_next = e_next; v.e_mp = e_mp; v.e_red = e_red;
      return v;
   endfunction

   initial begin
      logic [15:0] e_pt, e_nx, e_tg, e_mp, e_rd;
      bit          do_rst;

      vecs[0]  = mk(16'h0012, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0013, 0, 16'h0000);
      vecs[1]  = mk(16'h0012, 1, 16'h0012, 1, 16'h0040, 0, 16'h0000, 0, 16'h0013, 1, 16'h0040);
      vecs[2]  = mk(16'h0012, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 16'h0040, 0, 16'h0000);
      vecs[3]  = mk(16'h0012, 1, 16'h0012, 0, 16'h0000, 1, 16'h0040, 1, 16'h0040, 1, 16'h0013);
      vecs[4]  = mk(16'h0012, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0013, 0, 16'h0000);
      vecs[5]  = mk(16'h0012, 1, 16'h0012, 0, 16'h0000, 0, 16'h0000, 0, 16'h0013, 0, 16'h0000);
      vecs[6]  = mk(16'h0012, 1, 16'h0012, 0, 16'h0000, 0, 16'h0000, 0, 16'h0013, 0, 16'h0000);
      vecs[7]  = mk(16'h0012, 1, 16'h0012, 1, 16'h0040, 0, 16'h0000, 0, 16'h0013, 1, 16'h0040);
      vecs[8]  = mk(16'h0012, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0013, 0, 16'h0000);
      vecs[9]  = mk(16'h0012, 1, 16'h0012, 1, 16'h0040, 0, 16'h0000, 0, 16'h0013, 1, 16'h0040);
      vecs[10] = mk(16'h0012, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 16'h0040, 0, 16'h0000);
      vecs[11] = mk(16'h0102, 1, 16'h0102, 1, 16'h0200, 0, 16'h0000, 0, 16'h0103, 1, 16'h0200);
      vecs[12] = mk(16'h0012, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0013, 0, 16'h0000);
      vecs[13] = mk(16'h0102, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 16'h0200, 0, 16'h0000);
      vecs[14] = mk(16'hFFFF, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000);
      vecs[15] = mk(16'h0102, 1, 16'h0102, 1, 16'h0200, 1, 16'h0200, 1, 16'h0200, 0, 16'h0000);
      vecs[16] = mk(16'h0102, 1, 16'h0102, 1, 16'h0300, 1, 16'h0200, 1, 16'h0200, 1, 16'h0300);
      vecs[17] = mk(16'h0102, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 16'h0300, 0, 16'h0000);
      vecs[18] = mk(16'h0102, 1, 16'h0102, 0, 16'h0000, 1, 16'h0300, 1, 16'h0300, 1, 16'h0103);
      vecs[19] = mk(16'h0102, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 16'h0300, 0, 16'h0000);
      vecs[20] = mk(16'hFFFF, 1, 16'hFFFF, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000);
      vecs[21] = mk(16'hFFFF, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000);

      // clock/reset
      reset = 1'b1;
      drive(16'h0012, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000);
      tick();
      tick();
      reset = 1'b0;
      #2;
      check("reset_stat_br", stat_branches, 16'h0000);
      check("reset_stat_mp", stat_mispredicts, 16'h0000);
      check("reset_pred_target", pred_target, 16'h0000);

      for (int i = 0; i < 22; i++) begin
         drive(vecs[i].if_pc, vecs[i].uv, vecs[i].upc, vecs[i].ut, vecs[i].utg,
               vecs[i].upt, vecs[i].uptg);
         #2;
         check($sformatf("vec%0d_pred_taken", i), {15'd0, pred_taken}, {15'd0, vecs[i].e_pt});
         check($sformatf("vec%0d_pc_next", i), pred_pc_next, vecs[i].e_next);
         check($sformatf("vec%0d_mispredict", i), {15'd0, mispredict}, {15'd0, vecs[i].e_mp});
         if (vecs[i].e_mp)
            check($sformatf("vec%0d_redirect", i), redirect_pc, vecs[i].e_red);
         tick();
      end
      drive(16'h0012, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000);
      #2;
      check("table_stat_br", stat_branches, exp_stat(11));
      check("table_stat_mp", stat_mispredicts, exp_stat(7));

      // five updates, two mispredicts, from a fresh table
      reset = 1'b1;
      tick();
      reset = 1'b0;
      drive(16'h0000, 1, 16'h0021, 1, 16'h0050, 0, 16'h0000); tick();
      drive(16'h0000, 1, 16'h0021, 1, 16'h0050, 1, 16'h0050); tick();
      drive(16'h0000, 1, 16'h0021, 1, 16'h0050, 1, 16'h0050); tick();
      drive(16'h0000, 1, 16'h0021, 0, 16'h0000, 1, 16'h0050); tick();
      drive(16'h0000, 1, 16'h0033, 0, 16'h0000, 0, 16'h0000); tick();
      drive(16'h0021, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000);
      #2;
      check("seq_stat_br", stat_branches, exp_stat(5));
      check("seq_stat_mp", stat_mispredicts, exp_stat(2));
      check("seq_pred_taken", {15'd0, pred_taken}, 16'h0001);

      // reset together with an update: update is discarded
      reset = 1'b1;
      drive(16'h0021, 1, 16'h0044, 1, 16'h0060, 0, 16'h0000);
      tick();
      reset = 1'b0;
      drive(16'h0021, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000);
      #2;
      check("rstupd_stat_br", stat_branches, 16'h0000);
      check("rstupd_stat_mp", stat_mispredicts, 16'h0000);
      check("rstupd_pt_0021", {15'd0, pred_taken}, 16'h0000);
      check("rstupd_next_0021", pred_pc_next, 16'h0022);
      if_pc = 16'h0044;
      #1;
      check("rstupd_pt_0044", {15'd0, pred_taken}, 16'h0000);
      check("rstupd_next_0044", pred_pc_next, 16'h0045);
      check("rstupd_tgt_0044", pred_target, 16'h0000);
      tick();

      // randomized traffic against the model
      reset = 1'b1;
      tick();
      reset = 1'b0;
      m_clear();
      for (int n = 0; n < 800; n++) begin
         logic [15:0] pc, upc, utg, uptg;
         logic        uv, ut, upt;
         pc  = rand_pc();
         upc = rand_pc();
         uv  = ($urandom_range(0, 3) != 0);
         ut  = $urandom_range(0, 1);
         utg = ($urandom_range(0, 1) != 0) ? 16'(16'h0400 + $urandom_range(0, 3)) : 16'($urandom);
         if ($urandom_range(0, 3) != 0) begin
            upt  = m_taken(upc);
            uptg = m_target(upc);
         end else begin
            upt  = $urandom_range(0, 1);
            uptg = 16'(16'h0400 + $urandom_range(0, 3));
         end
         do_rst = ($urandom_range(0, 59) == 0);
         reset  = do_rst;
         drive(pc, uv, upc, ut, utg, upt, uptg);

         e_pt = {15'd0, m_taken(pc)};
         e_nx = m_next(pc);
         e_tg = m_target(pc);
         e_mp = {15'd0, uv && ((ut != upt) || (ut && (utg != uptg)))};
         e_rd = ut ? utg : 16'(upc + 16'd1);
         exp_q.push_back(e_pt);
         exp_q.push_back(e_nx);
         exp_q.push_back(e_tg);
         exp_q.push_back(e_mp);
         #2;
         check("rnd_pred_taken", {15'd0, pred_taken}, exp_q.pop_front());
         check("rnd_pc_next", pred_pc_next, exp_q.pop_front());
         check("rnd_pred_target", pred_target, exp_q.pop_front());
         check("rnd_mispredict", {15'd0, mispredict}, exp_q.pop_front());
         if (e_mp[0])
            check("rnd_redirect", redirect_pc, e_rd);
         check("rnd_stat_br", stat_branches, exp_stat(m_br));
         check("rnd_stat_mp", stat_mispredicts, exp_stat(m_mp));
         tick();
         if (do_rst) m_clear();
         else if (uv) m_update(upc, ut, utg, e_mp[0]);
      end
      reset = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
